// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin port onto a single-port memory, with fill sweep after reset or on request
module mem_port_arbiter #(
  parameter int                 WID_MEM   = 1,
  parameter int                 DEPTH_MEM = 65536,
  parameter logic [WID_MEM-1:0] FILL_VAL  = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init_start,
  output logic               init_busy,
  input  logic               a_valid,
  input  logic               b_valid,
  output logic               a_ready,
  output logic               b_ready,
  input  logic               a_we,
  input  logic               b_we,
  input  logic [31:0]        a_addr,
  input  logic [31:0]        b_addr,
  input  logic [WID_MEM-1:0] a_wdata,
  input  logic [WID_MEM-1:0] b_wdata,
  output logic               a_rsp_valid,
  output logic               b_rsp_valid,
  output logic [WID_MEM-1:0] a_rdata,
  output logic [WID_MEM-1:0] b_rdata,
  output logic               a_err,
  output logic               b_err,
  output logic [31:0]        mem_raddr,
  output logic [31:0]        mem_waddr,
  output logic               mem_we,
  output logic [WID_MEM-1:0] mem_din,
  input  logic [WID_MEM-1:0] mem_dout
);
  typedef enum logic {INIT, RUN} state_t;
  state_t              r_state, w_state_nxt;
  logic [31:0]         r_cnt, w_cnt_nxt, r_raddr, w_addr;
  logic                r_last_b, r_rsp_a, r_rsp_b, r_rsp_oor;
  logic                w_init, w_run, w_grant_a, w_grant_b, w_grant, w_we, w_oor;
  logic [WID_MEM-1:0]  w_wdata;

  // FSM state and sweep counter; reset restarts the sweep from word 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Arbitration, next state and all memory/requester outputs
  always_comb begin
    w_init      = reset && (r_state == INIT);
    w_run       = reset && (r_state == RUN);
    w_grant_a   = w_run && a_valid && (!b_valid || r_last_b);
    w_grant_b   = w_run && b_valid && !w_grant_a;
    w_grant     = w_grant_a || w_grant_b;
    w_addr      = w_grant_b ? b_addr : a_addr;
    w_wdata     = w_grant_b ? b_wdata : a_wdata;
    w_we        = w_grant_b ? b_we : a_we;
    w_oor       = w_addr >= 32'(DEPTH_MEM);
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == INIT) begin
      w_state_nxt = (r_cnt == 32'(DEPTH_MEM - 1)) ? RUN : INIT;
      w_cnt_nxt   = (r_cnt == 32'(DEPTH_MEM - 1)) ? '0 : r_cnt + 32'd1;
    end else if (init_start) begin
      w_state_nxt = INIT;
      w_cnt_nxt   = '0;
    end
    init_busy   = !w_run;
    a_ready     = w_grant_a;
    b_ready     = w_grant_b;
    a_err       = w_grant_a && w_oor;
    b_err       = w_grant_b && w_oor;
    mem_we      = w_init || (w_grant && w_we && !w_oor);
    mem_waddr   = w_init ? r_cnt : (mem_we ? w_addr : '0);
    mem_din     = w_init ? FILL_VAL : (mem_we ? w_wdata : '0);
    mem_raddr   = (w_grant && !w_we) ? w_addr : r_raddr;
    a_rsp_valid = r_rsp_a;
    b_rsp_valid = r_rsp_b;
    a_rdata     = (r_rsp_a && !r_rsp_oor) ? mem_dout : '0;
    b_rdata     = (r_rsp_b && !r_rsp_oor) ? mem_dout : '0;
  end

  // Round-robin pointer, held read address and one-cycle read response tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_b  <= 1'b1;
      r_raddr   <= '0;
      r_rsp_a   <= 1'b0;
      r_rsp_b   <= 1'b0;
      r_rsp_oor <= 1'b0;
    end else begin
      if (w_grant) r_last_b <= w_grant_b;
      r_raddr   <= mem_raddr;
      r_rsp_a   <= w_grant_a && !w_we;
      r_rsp_b   <= w_grant_b && !w_we;
      r_rsp_oor <= w_oor;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a read-response scoreboard against a behavioural memory
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init_start = 1'b0;
  logic        init_busy;
  logic        a_valid = 1'b0, b_valid = 1'b0, a_ready, b_ready;
  logic        a_we = 1'b0, b_we = 1'b0;
  logic [31:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;
  logic        a_rsp_valid, b_rsp_valid, a_err, b_err;
  logic [7:0]  a_rdata, b_rdata;
  logic [31:0] mem_raddr, mem_waddr;
  logic        mem_we;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem [0:15];
  logic [7:0]  qa[$], qb[$];
  int          total = 0;
  int          bad = 0;

  mem_port_arbiter #(.WID_MEM(8), .DEPTH_MEM(16), .FILL_VAL(8'h5A)) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .init_busy(init_busy),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
    .a_we(a_we), .b_we(b_we), .a_addr(a_addr), .b_addr(b_addr),
    .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .a_err(a_err), .b_err(b_err),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with registered read data
  always @(posedge clk) begin
    if (mem_we && mem_waddr < 32'd16) mem[mem_waddr[3:0]] <= mem_din;
    mem_dout <= (mem_raddr < 32'd16) ? mem[mem_raddr[3:0]] : 8'h00;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic we, input logic [31:0] ad, input logic [7:0] d);
    a_valid = v; a_we = we; a_addr = ad; a_wdata = d;
  endtask

  task automatic drv_b(input logic v, input logic we, input logic [31:0] ad, input logic [7:0] d);
    b_valid = v; b_we = we; b_addr = ad; b_wdata = d;
  endtask

  // Scoreboard monitor: every response is matched against the queued expectation
  always @(negedge clk) begin
    if (reset) begin
      if (a_rsp_valid) begin
        if (qa.size() == 0) chk("a_rsp_unexpected", 32'd1, 32'd0);
        else chk("a_rdata", {24'd0, a_rdata}, {24'd0, qa.pop_front()});
        chk("b_rdata_idle", {24'd0, b_rdata}, 32'd0);
      end
      if (b_rsp_valid) begin
        if (qb.size() == 0) chk("b_rsp_unexpected", 32'd1, 32'd0);
        else chk("b_rdata", {24'd0, b_rdata}, {24'd0, qb.pop_front()});
        chk("a_rdata_idle", {24'd0, a_rdata}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drv_a(1'b1, 1'b0, 32'd0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_init_busy", {31'd0, init_busy}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_waddr", mem_waddr, 32'd0);
    chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
    chk("rst_mem_raddr", mem_raddr, 32'd0);
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    nxt();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("sweep_waddr", mem_waddr, 32'(i));
      chk("sweep_we", {31'd0, mem_we}, 32'd1);
      chk("sweep_din", {24'd0, mem_din}, 32'h5A);
      chk("sweep_a_ready", {31'd0, a_ready}, 32'd0);
      chk("sweep_busy", {31'd0, init_busy}, 32'd1);
      nxt();
      init_start = (i == 3);
    end
    init_start = 1'b0;
    drv_a(1'b1, 1'b1, 32'd5, 8'h01);
    @(negedge clk);
    chk("run_busy", {31'd0, init_busy}, 32'd0);
    chk("wr_a_ready", {31'd0, a_ready}, 32'd1);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_waddr", mem_waddr, 32'd5);
    chk("wr_din", {24'd0, mem_din}, 32'h01);
    nxt();
    drv_a(1'b1, 1'b0, 32'd5, 8'h00);
    @(negedge clk);
    chk("rd_a_ready", {31'd0, a_ready}, 32'd1);
    chk("rd_raddr", mem_raddr, 32'd5);
    chk("rd_we_low", {31'd0, mem_we}, 32'd0);
    qa.push_back(8'h01);
    nxt();
    drv_a(1'b0, 1'b0, 32'd9, 8'h00);
    @(negedge clk);
    chk("rd_lat_a", {31'd0, a_rsp_valid}, 32'd1);
    chk("raddr_hold", mem_raddr, 32'd5);
    nxt();
    drv_a(1'b1, 1'b1, 32'd1, 8'h11);
    drv_b(1'b1, 1'b1, 32'd2, 8'h22);
    @(negedge clk);
    chk("rr_w1_b", {30'd0, a_ready, b_ready}, 32'd1);
    chk("rr_w1_waddr", mem_waddr, 32'd2);
    nxt();
    drv_b(1'b0, 1'b0, 32'd0, 8'h00);
    @(negedge clk);
    chk("rr_w2_a", {30'd0, a_ready, b_ready}, 32'd2);
    chk("rr_w2_din", {24'd0, mem_din}, 32'h11);
    nxt();
    drv_a(1'b0, 1'b0, 32'd0, 8'h00);
    drv_b(1'b1, 1'b1, 32'd3, 8'h33);
    @(negedge clk);
    chk("rr_w3_b", {30'd0, a_ready, b_ready}, 32'd1);
    nxt();
    drv_a(1'b1, 1'b0, 32'd1, 8'h00);
    drv_b(1'b1, 1'b0, 32'd2, 8'h00);
    @(negedge clk);
    chk("rr_r1_a", {30'd0, a_ready, b_ready}, 32'd2);
    qa.push_back(8'h11);
    nxt();
    drv_a(1'b1, 1'b0, 32'd5, 8'h00);
    @(negedge clk);
    chk("rr_r2_b", {30'd0, a_ready, b_ready}, 32'd1);
    chk("rr_r2_lat", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd2);
    qb.push_back(8'h22);
    nxt();
    drv_b(1'b1, 1'b0, 32'd3, 8'h00);
    @(negedge clk);
    chk("rr_r3_a", {30'd0, a_ready, b_ready}, 32'd2);
    chk("rr_r3_lat", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd1);
    qa.push_back(8'h01);
    nxt();
    drv_a(1'b1, 1'b0, 32'd0, 8'h00);
    @(negedge clk);
    chk("rr_r4_b", {30'd0, a_ready, b_ready}, 32'd1);
    chk("rr_r4_lat", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd2);
    qb.push_back(8'h33);
    nxt();
    drv_a(1'b0, 1'b0, 32'd0, 8'h00);
    drv_b(1'b1, 1'b0, 32'd20, 8'h00);
    @(negedge clk);
    chk("r4_lat", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd1);
    chk("oor_rd_ready", {31'd0, b_ready}, 32'd1);
    chk("oor_rd_err", {31'd0, b_err}, 32'd1);
    qb.push_back(8'h00);
    nxt();
    drv_b(1'b1, 1'b1, 32'd20, 8'h77);
    @(negedge clk);
    chk("oor_rd_rsp", {31'd0, b_rsp_valid}, 32'd1);
    chk("oor_wr_ready", {31'd0, b_ready}, 32'd1);
    chk("oor_wr_err", {31'd0, b_err}, 32'd1);
    chk("oor_wr_we", {31'd0, mem_we}, 32'd0);
    nxt();
    drv_b(1'b0, 1'b0, 32'd0, 8'h00);
    @(negedge clk);
    chk("err_clear", {30'd0, a_err, b_err}, 32'd0);
    nxt();
    drv_a(1'b1, 1'b0, 32'd7, 8'h00);
    init_start = 1'b1;
    @(negedge clk);
    chk("init_pulse_grant", {31'd0, a_ready}, 32'd1);
    qa.push_back(8'h5A);
    nxt();
    init_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("reinit_a_ready", {31'd0, a_ready}, 32'd0);
      chk("reinit_waddr", mem_waddr, 32'(i));
      nxt();
    end
    for (int k = 0; k < 16; k++) begin
      a_addr = 32'(k);
      @(negedge clk);
      chk("readback_ready", {31'd0, a_ready}, 32'd1);
      chk("readback_raddr", mem_raddr, 32'(k));
      qa.push_back(8'h5A);
      nxt();
    end
    drv_a(1'b0, 1'b0, 32'd0, 8'h00);
    repeat (2) nxt();
    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);
    init_start = 1'b1;
    nxt();
    init_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("pre_rst_waddr", mem_waddr, 32'(i));
      if (i < 7) nxt();
    end
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, init_busy}, 32'd1);
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_waddr", mem_waddr, 32'd0);
    chk("mid_rst_din", {24'd0, mem_din}, 32'd0);
    nxt();
    nxt();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("restart_waddr", mem_waddr, 32'(i));
      chk("restart_we", {31'd0, mem_we}, 32'd1);
      nxt();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
